// File: rtl/scanline_double_buffer.sv
`timescale 1ns/1ps
// Two-bank scanline buffer: renderer fills one bank while video reads the other.
// Banks swap on line_swap once a line is complete; early swaps flag underrun.
module scanline_double_buffer #(
    parameter int H_ACTIVE = 640,
    parameter int COLOR_W  = 12,
    parameter int X_W      = 10
) (
    input  logic               Clk,
    input  logic               resetn,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               wr_last,
    input  logic               line_swap,
    output logic               line_req,
    input  logic [X_W-1:0]     drawX,
    input  logic               vde,
    output logic [COLOR_W-1:0] pixel_out,
    output logic               underrun,
    input  logic               underrun_clr
);

    localparam int A_W = $clog2(2 * H_ACTIVE);

    typedef enum logic {
        S_FILL,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_rd_bank;
    logic               r_active;
    logic               r_hit;
    logic [X_W-1:0]     r_wr_ptr;
    logic [X_W-1:0]     r_fill [2];
    logic [COLOR_W-1:0] r_rd_q;
    logic [COLOR_W-1:0] r_mem [2*H_ACTIVE];

    logic               w_wr_bank;
    logic               w_accept;
    logic               w_complete;
    logic               w_swap;
    logic               w_ur_set;
    logic               w_in_range;
    logic               w_rd_hit;
    logic [X_W-1:0]     w_rd_x;
    logic [A_W-1:0]     w_wr_addr;
    logic [A_W-1:0]     w_rd_addr;

    assign w_wr_bank  = ~r_rd_bank;
    assign wr_ready   = r_active && (r_state == S_FILL);
    assign w_accept   = wr_valid && wr_ready;
    assign w_complete = w_accept &&
                        (wr_last || r_wr_ptr == X_W'(H_ACTIVE - 1));
    // A write completing in the swap cycle still counts as a full line.
    assign w_swap     = line_swap && (r_state == S_DONE || w_complete);
    assign w_ur_set   = line_swap && !w_swap;

    assign w_in_range = drawX < X_W'(H_ACTIVE);
    assign w_rd_x     = w_in_range ? drawX : '0;
    assign w_rd_hit   = vde && w_in_range && (drawX < r_fill[r_rd_bank]);

    assign w_wr_addr = w_wr_bank ? A_W'(H_ACTIVE) + A_W'(r_wr_ptr)
                                 : A_W'(r_wr_ptr);
    assign w_rd_addr = r_rd_bank ? A_W'(H_ACTIVE) + A_W'(w_rd_x)
                                 : A_W'(w_rd_x);

    // Simple dual-port RAM, contents never reset.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= wr_data;
        end
        r_rd_q <= r_mem[w_rd_addr];
    end

    assign pixel_out = r_hit ? r_rd_q : '0;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_FILL;
            r_rd_bank <= 1'b0;
            r_active  <= 1'b0;
            r_hit     <= 1'b0;
            r_wr_ptr  <= '0;
            r_fill[0] <= '0;
            r_fill[1] <= '0;
            line_req  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_hit    <= w_rd_hit;
            line_req <= w_swap;
            underrun <= w_ur_set || (underrun && !underrun_clr);
            if (w_accept && !w_complete) begin
                r_wr_ptr <= r_wr_ptr + X_W'(1);
            end
            if (w_complete) begin
                r_fill[w_wr_bank] <= r_wr_ptr + X_W'(1);
                r_state           <= S_DONE;
            end
            if (w_swap) begin
                r_rd_bank <= ~r_rd_bank;
                r_wr_ptr  <= '0;
                r_state   <= S_FILL;
            end
        end
    end

endmodule

// File: tb/tb_scanline_double_buffer.sv
`timescale 1ns/1ps
// Randomised bench for scanline_double_buffer against a queue-based line model.
module tb_scanline_double_buffer;

    localparam int H  = 640;
    localparam int CW = 12;
    localparam int XW = 10;

    logic          Clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_last = 1'b0;
    logic          line_swap = 1'b0;
    logic          vde = 1'b0;
    logic          underrun_clr = 1'b0;
    logic [CW-1:0] wr_data = '0;
    logic [XW-1:0] drawX = '0;
    logic          wr_ready;
    logic          line_req;
    logic          underrun;
    logic [CW-1:0] pixel_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    scanline_double_buffer #(.H_ACTIVE(H), .COLOR_W(CW), .X_W(XW)) dut (
        .Clk(Clk),
        .resetn(resetn),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_last(wr_last),
        .line_swap(line_swap),
        .line_req(line_req),
        .drawX(drawX),
        .vde(vde),
        .pixel_out(pixel_out),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    // Model: the displayed line and the line under construction as queues.
    int            shown[$];
    int            building[$];
    bit            complete = 1'b0;
    bit            active = 1'b0;
    bit            m_ur = 1'b0;
    bit            e_lreq = 1'b0;
    logic [CW-1:0] e_pix = '0;

    task automatic model_step();
        bit acc;
        bit ur_set;
        int x;
        if (!resetn) begin
            shown.delete();
            building.delete();
            complete = 1'b0;
            active = 1'b0;
            m_ur = 1'b0;
            e_lreq = 1'b0;
            e_pix = '0;
        end else begin
            x = int'(drawX);
            e_pix = (vde && x < shown.size()) ? CW'(shown[x]) : '0;
            acc = wr_valid && active && !complete;
            if (acc) begin
                building.push_back(int'(wr_data));
                if (wr_last || building.size() == H) complete = 1'b1;
            end
            e_lreq = 1'b0;
            ur_set = 1'b0;
            if (line_swap) begin
                if (complete) begin
                    shown = building;
                    building.delete();
                    complete = 1'b0;
                    e_lreq = 1'b1;
                end else begin
                    ur_set = 1'b1;
                end
            end
            m_ur = ur_set || (m_ur && !underrun_clr);
            active = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge Clk or negedge resetn);
        model_step();
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            check("cmp_wr_ready", 32'(wr_ready), 32'(active && !complete));
            check("cmp_line_req", 32'(line_req), 32'(e_lreq));
            check("cmp_underrun", 32'(underrun), 32'(m_ur));
            check("cmp_pixel", 32'(pixel_out), 32'(e_pix));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_read();
        vde = ($urandom_range(0, 3) != 0);
        drawX = XW'($urandom_range(0, 700));
    endtask

    task automatic fill(int first, int n, int base, bit last, int bub);
        int i;
        int budget;
        bit acc;
        i = first;
        budget = n * 20 + 50;
        while (i < first + n) begin
            wr_valid = ($urandom_range(0, 99) >= bub);
            wr_data = CW'(base + i);
            wr_last = last && (i == first + n - 1);
            rand_read();
            acc = wr_valid && wr_ready;
            tick();
            if (acc) i++;
            budget--;
            if (budget == 0) begin
                check("fill_timeout", 32'(i), 32'(first + n));
                break;
            end
        end
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic swap();
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
    endtask

    task automatic rd(int x, bit v);
        drawX = XW'(x);
        vde = v;
        tick();
    endtask

    task automatic sweep(bit v);
        for (int x = 0; x < H + 8; x++) rd(x, v);
    endtask

    initial begin
        int n;
        int base;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_ready", 32'(wr_ready), 0);
        check("rst_pixel", 32'(pixel_out), 0);
        check("rst_line_req", 32'(line_req), 0);
        check("rst_underrun", 32'(underrun), 0);
        resetn = 1'b1;
        tick();
        check("ready_after_release", 32'(wr_ready), 1);

        // Full line, no bubbles.
        fill(0, H, 0, 1'b0, 0);
        check("ready_drop_full", 32'(wr_ready), 0);
        swap();
        check("line_req_pulse", 32'(line_req), 1);
        tick();
        check("line_req_once", 32'(line_req), 0);
        sweep(1'b1);
        rd(639, 1'b1);
        check("full_px639", 32'(pixel_out), 32'h27f);

        // Early wr_last after 100 pixels.
        fill(0, 100, 0, 1'b1, 0);
        check("ready_drop_last", 32'(wr_ready), 0);
        swap();
        rd(99, 1'b1);
        check("short_px99", 32'(pixel_out), 32'h063);
        rd(100, 1'b1);
        check("short_px100", 32'(pixel_out), 32'h000);
        sweep(1'b0);
        rd(50, 1'b0);
        check("vde_low", 32'(pixel_out), 0);

        // Underrun: swap after 300 of 640.
        fill(0, 300, 'h100, 1'b0, 0);
        swap();
        check("underrun_set", 32'(underrun), 1);
        check("underrun_no_req", 32'(line_req), 0);
        rd(5, 1'b1);
        check("underrun_prior", 32'(pixel_out), 32'h005);
        fill(300, 340, 'h100, 1'b0, 0);
        swap();
        check("recover_req", 32'(line_req), 1);
        rd(639, 1'b1);
        check("recover_px639", 32'(pixel_out), 32'h37f);

        // Completing write coincides with swap.
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("underrun_clr", 32'(underrun), 0);
        fill(0, 639, 'h200, 1'b0, 0);
        wr_valid = 1'b1;
        wr_data = CW'('h200 + 639);
        line_swap = 1'b1;
        tick();
        wr_valid = 1'b0;
        line_swap = 1'b0;
        check("coll_no_underrun", 32'(underrun), 0);
        check("coll_req", 32'(line_req), 1);
        rd(639, 1'b1);
        check("coll_px639", 32'(pixel_out), 32'h47f);

        // Random bubbles and lengths over three lines.
        for (int l = 0; l < 3; l++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 639) : H;
            base = int'($urandom_range(0, 4095));
            fill(0, n, base, n < H, 50);
            repeat ($urandom_range(0, 5)) begin
                rand_read();
                tick();
            end
            swap();
            sweep(1'b1);
        end

        // Underrun set/clear collision, then reset mid-fill.
        fill(0, 200, 'h300, 1'b0, 0);
        swap();
        check("ur_set2", 32'(underrun), 1);
        underrun_clr = 1'b1;
        line_swap = 1'b1;
        tick();
        underrun_clr = 1'b0;
        line_swap = 1'b0;
        check("ur_set_clr_collide", 32'(underrun), 1);
        fill(200, 50, 'h300, 1'b0, 0);
        drawX = XW'(5);
        vde = 1'b1;
        resetn = 1'b0;
        #1;
        check("midrst_ready", 32'(wr_ready), 0);
        check("midrst_pixel", 32'(pixel_out), 0);
        check("midrst_underrun", 32'(underrun), 0);
        check("midrst_req", 32'(line_req), 0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("rerelease_ready", 32'(wr_ready), 1);
        rd(3, 1'b1);
        check("rerelease_empty", 32'(pixel_out), 0);
        fill(0, 10, 'h500, 1'b1, 0);
        swap();
        rd(3, 1'b1);
        check("restart_px3", 32'(pixel_out), 32'h503);
        rd(10, 1'b1);
        check("restart_px10", 32'(pixel_out), 0);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scanline_double_buffer.md
Name: scanline_double_buffer

Overview:
- Two-bank scanline buffer that sits directly upstream of the HDMI pixel path inside mb_usb_hdmi_top.
- The renderer streams one line of pixels into the write bank through a valid/ready handshake.
- The video timing side reads the other bank by drawX.
- Banks swap on a line-boundary pulse; an incomplete line at swap time is flagged as an underrun and the previous line is repeated.

Parameters:
- H_ACTIVE, 640, visible pixels per line and entries per bank.
- COLOR_W, 12, pixel width (4:4:4 RGB).
- X_W, 10, width of drawX and of the write pointer.

Ports:
- Clk  in  1  pixel clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- wr_valid  in  1  renderer pixel valid.
- wr_ready  out  1  buffer can accept a pixel.
- wr_data  in  COLOR_W  pixel colour.
- wr_last  in  1  final pixel of the line; may arrive early.
- line_swap  in  1  one-cycle pulse at start of hblank.
- line_req  out  1  one-cycle pulse: renderer may begin the next line.
- drawX  in  X_W  current pixel column from the timing generator.
- vde  in  1  video data enable.
- pixel_out  out  COLOR_W  registered pixel to the TMDS encoder.
- underrun  out  1  sticky: a swap arrived before the line was complete.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (async, resetn=0): rd_bank=0, wr_bank=1, state FILL, wr_ptr=0, both fill counts=0, wr_ready=0 while resetn low, line_req=0, pixel_out=0, underrun=0.
- Release from reset is synchronous to Clk; wr_ready=1 from the first cycle after release.
- Write FSM states: FILL, DONE.
- FILL:
  - wr_ready=1.
  - Accept on wr_valid&&wr_ready: write wr_data to wr_bank[wr_ptr], then wr_ptr++.
  - An accept with wr_last=1, or an accept at wr_ptr==H_ACTIVE-1, records fill count (wr_ptr+1) and moves to DONE.
- DONE:
  - wr_ready=0; wr_valid is ignored.
  - On line_swap: toggle rd_bank/wr_bank, wr_ptr=0, next state FILL, pulse line_req high for exactly the following cycle.
- line_swap while in FILL (underrun):
  - No bank swap; rd_bank keeps showing the previous line.
  - underrun set; writing continues uninterrupted; no line_req.
- Simultaneous completing write and line_swap in the same cycle: the write is taken, the line counts as complete, and the swap occurs in that cycle; no underrun.
- The fill count travels with its bank on swap.
- Read path, 1-cycle latency: pixel_out(t+1) is
  - 0 if vde(t)=0, or drawX(t)>=H_ACTIVE, or drawX(t)>=fill count of rd_bank;
  - otherwise rd_bank[drawX(t)].
- A write to wr_bank never affects pixel_out in the same or any later cycle until a swap; the banks are fully independent.
- underrun_clr clears underrun; a set and a clear in the same cycle leave underrun=1.
- wr_ptr never exceeds H_ACTIVE-1. The pointer does not wrap; completion forces DONE.
- Banks are inferred as simple dual-port RAM: one write port (wr side), one read port (rd side). No reset of RAM contents.
- Reset asserted mid-line: state returns to FILL with wr_ptr=0 and fill counts=0, so pixel_out reads 0 until the first completed line is swapped in.

Test Plan:
- Reset then fill 640 pixels wr_data=x, no bubbles, then line_swap -> wr_ready drops the cycle after pixel 639; line_req pulses 1 cycle after swap. Sweeping drawX 0..639 with vde=1 gives pixel_out=drawX one cycle later.
- Write 100 pixels with wr_last on the 100th, swap, read drawX=99 and drawX=100 -> 0x063 then 0x000. With vde=0, pixel_out=0 for every drawX.
- line_swap after only 300 of 640 pixels -> underrun=1, no line_req, pixel_out still shows the prior line. Complete the remaining 340 pixels and swap again -> new line displayed, line_req pulses.
- Final write (pixel 639) and line_swap in the same cycle -> swap occurs, underrun stays 0, line_req pulses next cycle.
- Random wr_valid bubbles (~50%) over 3 lines, each swapped after completion -> the displayed data matches each line exactly, and no write is lost or duplicated.
- Assert resetn=0 for 3 cycles mid-fill, with underrun=1 and the underrun_clr/set collision also tested -> all outputs 0 immediately; after release wr_ready=1 and wr_ptr restarts at 0.
